uart_tx_serializer: RTL and testbench

UART transmit serializer that sits directly downstream of the baud generator. It takes a parallel byte through a start/busy handshake, frames it as start + data (LSB first) + optional parity + stop bit(s), and drives the serial line. Bit boundaries are paced by rising edges of the generator's `baud_clk`, which is a same-clock-domain register output. The serializer detects those edges synchronously and never uses `baud_clk` as a clock.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_baud_tick.sv | 22 ++
 rtl/uart_tx_serializer.sv | 130 +++++++++++++
 tb/tb_uart_tx_serializer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and line levels for the transmit serializer and the future receiver.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
    } uart_tx_state_t;

    localparam logic UART_IDLE_LEVEL  = 1'b1;
    localparam logic UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/uart_baud_tick.sv
// Rising-edge detector on the same-domain baud_clk; tick is combinational off one register, zero added latency.
// No backpressure: every rising edge produces exactly one single-cycle tick.
module uart_baud_tick (
    input  logic clk,
    input  logic rst_n,
    input  logic baud_clk,
    output logic tick
);

    logic baud_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            baud_q <= 1'b0;
        end else begin
            baud_q <= baud_clk;
        end
    end

    assign tick = baud_clk & ~baud_q;

endmodule

// File: rtl/uart_tx_serializer.sv
// UART framer: start + DATA_BITS (LSB first) + optional parity + STOP_BITS, one bit per baud tick; start bit within one baud period + 1 clk of accept.
// Handshake is start/busy: tx_start is dropped while tx_busy is high, and is accepted again in the tx_done cycle.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_clk,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    output logic                 tx,
    output logic                 tx_busy,
    output logic                 tx_done
);

    localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    uart_tx_state_t       state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 par_en_q, par_en_d;
    logic                 par_bit_q, par_bit_d;
    logic                 tx_d, busy_d, done_d;
    logic                 tick;

    uart_baud_tick u_baud_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_clk (baud_clk),
        .tick     (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx         <= UART_IDLE_LEVEL;
            tx_busy    <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            tx         <= tx_d;
            tx_busy    <= busy_d;
            tx_done    <= done_d;
        end
    end

    // A tick coinciding with accept is not seen in IDLE, so SYNC always waits for the next full period.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (tx_start) state_d = SYNC;
            SYNC:    if (tick) state_d = START;
            START:   if (tick) state_d = DATA;
            DATA:    if (tick && bit_cnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick && stop_cnt_q == LAST_STOP) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx_d       = tx;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        done_d     = 1'b0;
        busy_d     = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                tx_d = UART_IDLE_LEVEL;
                if (tx_start) begin
                    shreg_d   = tx_data;
                    par_en_d  = parity_en;
                    par_bit_d = (^tx_data) ^ parity_odd;
                end
            end
            SYNC: if (tick) tx_d = UART_START_LEVEL;
            START: if (tick) begin
                tx_d      = shreg_q[0];
                bit_cnt_d = 3'd0;
            end
            DATA: if (tick) begin
                if (bit_cnt_q == LAST_BIT) begin
                    if (par_en_q) begin
                        tx_d = par_bit_q;
                    end else begin
                        tx_d       = UART_IDLE_LEVEL;
                        stop_cnt_d = 1'b0;
                    end
                end else begin
                    shreg_d   = shreg_q >> 1;
                    tx_d      = shreg_q[1];
                    bit_cnt_d = bit_cnt_q + 3'd1;
                end
            end
            PARITY: if (tick) begin
                tx_d       = UART_IDLE_LEVEL;
                stop_cnt_d = 1'b0;
            end
            STOP: if (tick) begin
                if (stop_cnt_q == LAST_STOP) begin
                    done_d = 1'b1;
                end else begin
                    stop_cnt_d = stop_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer: one 1-stop instance and one 2-stop instance on a shared 8-clock baud period.
`timescale 1ns/1ps
module tb_uart_tx_serializer;

    logic       clk;
    logic       rst_n;
    logic [1:0] bdiv     = 2'd0;
    logic       baud_clk = 1'b0;
    logic       start1, start2;
    logic [7:0] tx_data;
    logic       parity_en, parity_odd;
    logic       tx1, busy1, done1;
    logic       tx2, busy2, done2;
    logic       sel2;
    logic       cur_tx, cur_busy, cur_done;

    int checks    = 0;
    int errors    = 0;
    int done_cnt  = 0;
    int busy_cyc  = 0;
    int sync      = 0;
    int t         = 0;
    int lows      = 0;
    logic [15:0] bits;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Baud generator model: toggles every 4 clocks, so one bit period is 8 clocks.
    always @(posedge clk) begin
        bdiv <= bdiv + 2'd1;
        if (bdiv == 2'd3) baud_clk <= ~baud_clk;
    end

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_start(start1), .tx_data(tx_data),
        .parity_en(parity_en), .parity_odd(parity_odd), .tx(tx1), .tx_busy(busy1), .tx_done(done1)
    );

    uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .baud_clk(baud_clk), .tx_start(start2), .tx_data(tx_data),
        .parity_en(parity_en), .parity_odd(parity_odd), .tx(tx2), .tx_busy(busy2), .tx_done(done2)
    );

    assign cur_tx   = sel2 ? tx2   : tx1;
    assign cur_busy = sel2 ? busy2 : busy1;
    assign cur_done = sel2 ? done2 : done1;

    always @(negedge clk) begin
        if (cur_done === 1'b1) done_cnt++;
        if (cur_busy === 1'b1) busy_cyc++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic s2, input logic [7:0] d, input logic pen, input logic podd);
        @(negedge clk);
        sel2       = s2;
        tx_data    = d;
        parity_en  = pen;
        parity_odd = podd;
        done_cnt   = 0;
        busy_cyc   = 0;
        if (s2) start2 = 1'b1;
        else    start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        start2 = 1'b0;
    endtask

    // Samples each bit mid-period; optionally injects a busy-time start at bit inj,
    // or re-arms tx_start with nxt in the tx_done cycle when chain is set.
    task automatic capture(input int nbits, input int inj, input logic chain, input logic [7:0] nxt,
                           output logic [15:0] fbits, output int fsync);
        int tw;
        int off;
        fbits = '0;
        fsync = 0;
        tw    = 0;
        while (cur_tx !== 1'b0 && tw < 40) begin
            if (cur_busy === 1'b1) fsync++;
            @(negedge clk);
            tw++;
        end
        check("start_edge_seen", {31'd0, cur_tx}, 32'd0);
        repeat (4) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            if (i > 0) begin
                if (i == inj) begin
                    tx_data = 8'hFF;
                    start1  = 1'b1;
                end
                repeat (8) begin
                    @(negedge clk);
                    start1 = 1'b0;
                end
            end
            fbits[i] = cur_tx;
        end
        off = 0;
        do begin
            @(negedge clk);
            off++;
        end while (cur_done !== 1'b1 && off < 12);
        check("done_position", 32'(off), 32'd4);
        if (chain && cur_done === 1'b1) begin
            tx_data = nxt;
            start1  = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b1; start1 = 1'b0; start2 = 1'b0; sel2 = 1'b0;
        tx_data = 8'h00; parity_en = 1'b0; parity_odd = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_tx",    {31'd0, tx1},   32'd1);
        check("reset_busy",  {31'd0, busy1}, 32'd0);
        check("reset_done",  {31'd0, done1}, 32'd0);
        check("reset_tx2",   {31'd0, tx2},   32'd1);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic 0xA5, no parity, one stop: 0,1,0,1,0,0,1,0,1,1
        send(1'b0, 8'hA5, 1'b0, 1'b0);
        capture(10, -1, 1'b0, 8'h00, bits, sync);
        check("basic_frame", {16'd0, bits}, 32'h34A);
        check("basic_sync_range", {31'd0, (sync >= 1 && sync <= 8)}, 32'd1);
        repeat (4) @(negedge clk);
        check("basic_done_count", 32'(done_cnt), 32'd1);
        check("basic_busy_low",   {31'd0, busy1}, 32'd0);
        check("basic_busy_len",   32'(busy_cyc), 32'(80 + sync));

        // Parity frames, 11 ticks each
        send(1'b0, 8'hA5, 1'b1, 1'b0);
        capture(11, -1, 1'b0, 8'h00, bits, sync);
        check("par_a5_even", {16'd0, bits}, 32'h54A);
        send(1'b0, 8'hA5, 1'b1, 1'b1);
        capture(11, -1, 1'b0, 8'h00, bits, sync);
        check("par_a5_odd", {16'd0, bits}, 32'h74A);
        send(1'b0, 8'hFF, 1'b1, 1'b1);
        capture(11, -1, 1'b0, 8'h00, bits, sync);
        check("par_ff_odd", {16'd0, bits}, 32'h7FE);
        repeat (4) @(negedge clk);
        check("par_done_count", 32'(done_cnt), 32'd1);

        // Two stop bits with 0x00: nine lows then two highs
        send(1'b1, 8'h00, 1'b0, 1'b0);
        capture(11, -1, 1'b0, 8'h00, bits, sync);
        check("stop2_frame", {16'd0, bits}, 32'h600);
        repeat (4) @(negedge clk);
        check("stop2_done_count", 32'(done_cnt), 32'd1);

        // Busy rejection: 0xFF request during 0x3C
        send(1'b0, 8'h3C, 1'b0, 1'b0);
        capture(10, 4, 1'b0, 8'h00, bits, sync);
        check("reject_frame", {16'd0, bits}, 32'h278);
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx1 !== 1'b1 || busy1 !== 1'b0) lows++;
        end
        check("reject_no_second_frame", 32'(lows), 32'd0);
        check("reject_done_count", 32'(done_cnt), 32'd1);

        // Back-to-back: 0x0F then 0x55 accepted in the tx_done cycle
        send(1'b0, 8'h0F, 1'b0, 1'b0);
        capture(10, -1, 1'b1, 8'h55, bits, sync);
        check("b2b_first_frame", {16'd0, bits}, 32'h21E);
        @(negedge clk);
        start1 = 1'b0;
        check("b2b_busy_after_accept", {31'd0, busy1}, 32'd1);
        capture(10, -1, 1'b0, 8'h00, bits, sync);
        check("b2b_sync_len", 32'(sync), 32'd7);
        check("b2b_second_frame", {16'd0, bits}, 32'h2AA);
        repeat (6) @(negedge clk);

        // Reset during data bit 3 of 0xC3 (bit 3 is 0, so the line is low)
        send(1'b0, 8'hC3, 1'b0, 1'b0);
        t = 0;
        while (tx1 !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("rst_frame_started", {31'd0, tx1}, 32'd0);
        repeat (36) @(negedge clk);
        check("rst_pre_tx", {31'd0, tx1}, 32'd0);
        rst_n = 1'b0;
        #1;
        check("rst_async_tx",   {31'd0, tx1},   32'd1);
        check("rst_async_busy", {31'd0, busy1}, 32'd0);
        check("rst_async_done", {31'd0, done1}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(1'b0, 8'h81, 1'b0, 1'b0);
        capture(10, -1, 1'b0, 8'h00, bits, sync);
        check("post_rst_frame", {16'd0, bits}, 32'h302);
        repeat (4) @(negedge clk);
        check("post_rst_done_count", 32'(done_cnt), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
